// File: rtl/rf_2p_drv_pkg.sv
// Shared types and constants for the two-port register-file pattern driver.
package rf_2p_drv_pkg;

  typedef enum logic [1:0] {
    MODE_WR,
    MODE_RD,
    MODE_WR_RD,
    MODE_CONC
  } mode_e;

  typedef enum logic [1:0] {
    PAT_ZERO,
    PAT_ONE,
    PAT_CHK,
    PAT_ADDR
  } pattern_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CONC,
    DRAIN,
    DONE
  } state_e;

  // Wide enough for any practical macro width; users slice the low BITS.
  localparam int MAX_BITS = 256;

  // Checkerboard word used on even addresses ('h55.., bit 0 set).
  localparam logic [MAX_BITS-1:0] CHK_EVEN = {(MAX_BITS/2){2'b01}};

endpackage

// File: rtl/rf_2p_pattern_gen.sv
// Combinational data-pattern generator: maps an address to its test word.
module rf_2p_pattern_gen
  import rf_2p_drv_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int BITS       = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            pattern,
  input  logic [BITS-1:0]       seed,
  output logic [BITS-1:0]       data
);

  localparam int REPS = (BITS + ADDR_WIDTH - 1) / ADDR_WIDTH;

  logic [BITS-1:0] addr_rep;
  logic [BITS-1:0] chk_even;

  assign addr_rep = BITS'({REPS{addr}});
  assign chk_even = CHK_EVEN[BITS-1:0];

  // Select the word for this address according to the requested pattern.
  always_comb begin
    data = '0;
    case (pattern_e'(pattern))
      PAT_ZERO: data = '0;
      PAT_ONE:  data = '1;
      PAT_CHK:  data = addr[0] ? ~chk_even : chk_even;
      PAT_ADDR: data = addr_rep ^ seed;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/rf_2p_pattern_driver.sv
// Write/read-back sequencer for the two-port register-file macro wrapper.
module rf_2p_pattern_driver
  import rf_2p_drv_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int BITS       = 32,
  parameter int ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [1:0]            pattern,
  input  logic [BITS-1:0]       seed,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  CENA,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic                  CENB,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QA,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state;
  mode_e                 mode_q;
  logic [1:0]            pattern_q;
  logic [BITS-1:0]       seed_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [ADDR_WIDTH-1:0] cnt_dec;
  logic [BITS-1:0]       wr_data;
  logic [BITS-1:0]       exp_data;

  logic                  pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [BITS-1:0]       pipe_exp;

  assign cnt_inc = cnt + 1'b1;
  assign cnt_dec = cnt[ADDR_WIDTH-1:0] - 1'b1;

  rf_2p_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BITS(BITS)) u_gen_wr (
    .addr    (cnt[ADDR_WIDTH-1:0]),
    .pattern (pattern_q),
    .seed    (seed_q),
    .data    (wr_data)
  );

  rf_2p_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BITS(BITS)) u_gen_exp (
    .addr    (AA),
    .pattern (pattern_q),
    .seed    (seed_q),
    .data    (exp_data)
  );

  // Sequencer: walks the address counter and drives registered port A/B controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_WR;
      pattern_q <= '0;
      seed_q    <= '0;
      n_q       <= '0;
      cnt       <= '0;
      CENA      <= 1'b1;
      AA        <= '0;
      CENB      <= 1'b1;
      AB        <= '0;
      DB        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      CENA <= 1'b1;
      CENB <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode_e'(mode);
            pattern_q <= pattern;
            seed_q    <= seed;
            n_q       <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
            cnt       <= '0;
            busy      <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
            end else begin
              case (mode_e'(mode))
                MODE_RD:   state <= READ;
                MODE_CONC: state <= CONC;
                default:   state <= WRITE;
              endcase
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state <= DRAIN;
          end else begin
            CENB <= 1'b0;
            AB   <= cnt[ADDR_WIDTH-1:0];
            DB   <= wr_data;
            cnt  <= cnt_inc;
            if (cnt_inc == n_q) begin
              cnt   <= '0;
              state <= (mode_q == MODE_WR_RD) ? READ : DONE;
            end
          end
        end
        READ: begin
          if (abort) begin
            state <= DRAIN;
          end else begin
            CENA <= 1'b0;
            AA   <= cnt[ADDR_WIDTH-1:0];
            cnt  <= cnt_inc;
            if (cnt_inc == n_q) state <= DRAIN;
          end
        end
        CONC: begin
          if (abort) begin
            state <= DRAIN;
          end else begin
            if (cnt != n_q) begin
              CENB <= 1'b0;
              AB   <= cnt[ADDR_WIDTH-1:0];
              DB   <= wr_data;
            end
            if (cnt != '0) begin
              CENA <= 1'b0;
              AA   <= cnt_dec;
            end
            cnt <= cnt_inc;
            if (cnt == n_q) state <= DRAIN;
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-data compare: one-deep pipeline tracks the read the macro sampled last edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid     <= 1'b0;
      pipe_addr      <= '0;
      pipe_exp       <= '0;
      err            <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      pipe_valid <= ~CENA;
      pipe_addr  <= AA;
      pipe_exp   <= exp_data;
      if (state == IDLE && start) begin
        err            <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (pipe_valid && (QA != pipe_exp)) begin
        err <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!err) first_err_addr <= pipe_addr;
      end
    end
  end

endmodule

// File: tb/tb_rf_2p_pattern_driver.sv
// Self-checking bench for rf_2p_pattern_driver with a behavioural macro model.
module tb_rf_2p_pattern_driver;

  localparam int AW    = 7;
  localparam int BITS  = 32;
  localparam int ERR_W = 16;
  localparam int DEPTH = 128;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [1:0]      mode;
  logic [1:0]      pattern;
  logic [BITS-1:0] seed;
  logic [AW:0]     num_words;
  logic            CENA;
  logic [AW-1:0]   AA;
  logic            CENB;
  logic [AW-1:0]   AB;
  logic [BITS-1:0] DB;
  logic [BITS-1:0] QA;
  logic            busy;
  logic            done;
  logic            err;
  logic [ERR_W-1:0] err_count;
  logic [AW-1:0]   first_err_addr;

  logic [BITS-1:0] mem      [DEPTH];
  logic [BITS-1:0] load_img [DEPTH];
  logic [BITS-1:0] fault    [DEPTH];
  logic            load_req;

  int checks;
  int passed;

  rf_2p_pattern_driver #(.ADDR_WIDTH(AW), .BITS(BITS), .ERR_W(ERR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .pattern        (pattern),
    .seed           (seed),
    .num_words      (num_words),
    .CENA           (CENA),
    .AA             (AA),
    .CENB           (CENB),
    .AB             (AB),
    .DB             (DB),
    .QA             (QA),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal two-port macro with optional per-address read corruption.
  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= load_img[a];
    end else if (!CENB) begin
      mem[AB] <= DB;
    end
    if (!CENA) QA <= mem[AA] ^ fault[AA];
  end

  // Reference test word for address a.
  function automatic logic [BITS-1:0] pat_ref(input int a, input int p, input logic [BITS-1:0] s);
    logic [BITS-1:0] rep;
    rep = '0;
    case (p)
      0: return '0;
      1: return '1;
      2: return (a % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: begin
        for (int sh = 0; sh < BITS; sh += AW) rep = rep | (BITS'(a) << sh);
        return rep ^ s;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic clearFaults();
    for (int a = 0; a < DEPTH; a++) fault[a] = '0;
  endtask

  // Run one transaction and check everything observable against the spec rules.
  task automatic applyStimulus(input string tag, input int m, input int p, input logic [BITS-1:0] s,
                               input int n, input int abort_at);
    int n_eff, exp_w, exp_r, exp_acc, exp_busy, exp_cnt, exp_first;
    int wr_cnt, rd_cnt, wr_bad, rd_bad, coll, acc_cyc, busy_cyc, done_cnt;
    int done_cyc, last_rd_cyc, abort_cyc;
    bit got_done, aborted;
    logic cena_after_abort;

    n_eff = (n > DEPTH) ? DEPTH : n;
    for (int a = 0; a < DEPTH; a++) load_img[a] = (m == 1) ? pat_ref(a, p, s) : BITS'($urandom);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;

    mode = 2'(m); pattern = 2'(p); seed = s; num_words = (AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); pattern = 2'($urandom); seed = $urandom; num_words = (AW+1)'($urandom);

    wr_cnt = 0; rd_cnt = 0; wr_bad = 0; rd_bad = 0; coll = 0; acc_cyc = 0; busy_cyc = 0;
    done_cnt = 0; done_cyc = 0; last_rd_cyc = 0; abort_cyc = 0;
    got_done = 0; aborted = 0; cena_after_abort = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!CENB) begin
        if (int'(AB) != wr_cnt || DB !== pat_ref(int'(AB), p, s)) wr_bad++;
        wr_cnt++;
      end
      if (!CENA) begin
        if (int'(AA) != rd_cnt) rd_bad++;
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      if (!CENA && !CENB && AA == AB) coll++;
      if (!CENA || !CENB) acc_cyc++;
      if (busy) busy_cyc++;
      if (aborted && cyc == abort_cyc + 1) begin
        cena_after_abort = CENA;
        abort = 1'b0;
      end
      if (abort_at >= 0 && !aborted && !CENA && int'(AA) == abort_at) begin
        abort = 1'b1;
        aborted = 1;
        abort_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (!got_done) done_cyc = cyc;
        got_done = 1;
      end
      if (got_done && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    abort = 1'b0;

    exp_w = (m == 1) ? 0 : n_eff;
    exp_r = (m == 0) ? 0 : ((abort_at >= 0) ? abort_at + 1 : n_eff);
    if (abort_at >= 0) exp_acc = abort_at + 1;
    else if (m == 2) exp_acc = 2 * n_eff;
    else if (m == 3 && n_eff > 0) exp_acc = n_eff + 1;
    else exp_acc = n_eff;
    if (n_eff == 0) exp_busy = 1;
    else if (m == 0) exp_busy = n_eff + 1;
    else if (m == 1) exp_busy = n_eff + 2;
    else if (m == 2) exp_busy = 2 * n_eff + 2;
    else exp_busy = n_eff + 3;
    exp_cnt = 0; exp_first = 0;
    for (int a = 0; a < exp_r; a++) begin
      if (fault[a] != '0) begin
        if (exp_cnt == 0) exp_first = a;
        exp_cnt++;
      end
    end

    checkOutput({tag, "/done_seen"}, 64'(got_done), 1);
    checkOutput({tag, "/done_pulses"}, 64'(done_cnt), 1);
    checkOutput({tag, "/writes"}, 64'(wr_cnt), 64'(exp_w));
    checkOutput({tag, "/reads"}, 64'(rd_cnt), 64'(exp_r));
    checkOutput({tag, "/wr_order_data"}, 64'(wr_bad), 0);
    checkOutput({tag, "/rd_order"}, 64'(rd_bad), 0);
    checkOutput({tag, "/collisions"}, 64'(coll), 0);
    checkOutput({tag, "/access_cycles"}, 64'(acc_cyc), 64'(exp_acc));
    checkOutput({tag, "/err"}, 64'(err), 64'(exp_cnt > 0));
    checkOutput({tag, "/err_count"}, 64'(err_count), 64'(exp_cnt));
    if (exp_cnt > 0) checkOutput({tag, "/first_err_addr"}, 64'(first_err_addr), 64'(exp_first));
    if (abort_at >= 0) begin
      checkOutput({tag, "/cena_after_abort"}, 64'(cena_after_abort), 1);
      checkOutput({tag, "/abort_done_gap"}, 64'(done_cyc - last_rd_cyc), 3);
    end else begin
      checkOutput({tag, "/busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
      if (exp_r > 0) checkOutput({tag, "/done_gap"}, 64'(done_cyc - last_rd_cyc), 2);
    end
  endtask

  // Directed test-plan steps followed by randomized transactions.
  initial begin
    int wcount;
    bit reached;
    int m, p, n, k;
    logic [BITS-1:0] s;

    checks = 0; passed = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_req = 1'b0;
    mode = '0; pattern = '0; seed = '0; num_words = '0;
    for (int a = 0; a < DEPTH; a++) load_img[a] = '0;
    clearFaults();
    repeat (3) @(negedge clk);

    checkOutput("reset/enables", {62'b0, CENA, CENB}, 64'h3);
    checkOutput("reset/addr_data", {25'b0, AA, AB, DB}, 0);
    checkOutput("reset/status", {46'b0, busy, done, err, err_count}, 0);
    checkOutput("reset/first_err_addr", 64'(first_err_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] write-then-read checkerboard, 4 words");
    applyStimulus("wr_rd_chk4", 2, 2, 32'h0, 4, -1);

    $display("[TB] read-only addr-xor-seed with a corrupted word at 5");
    fault[5] = 32'h1;
    applyStimulus("rd_fault5", 1, 3, 32'hDEAD_BEEF, 8, -1);
    clearFaults();

    $display("[TB] reset during write at address 2 with start held");
    mode = 2'd0; pattern = 2'd1; seed = '0; num_words = (AW+1)'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 0;
    for (int c = 0; c < 50; c++) begin
      if (!CENB && AB == 7'd2) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rst_mid/reached_wr2", 64'(reached), 1);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid/enables", {62'b0, CENA, CENB}, 64'h3);
    checkOutput("rst_mid/status", {46'b0, busy, done, err, err_count}, 0);
    wcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (!CENB) wcount++;
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (!CENB) wcount++;
    end
    checkOutput("rst_mid/no_writes", 64'(wcount), 0);
    checkOutput("rst_mid/idle_busy", 64'(busy), 0);
    applyStimulus("after_rst", 0, 1, 32'h0, 6, -1);

    $display("[TB] concurrent mode over the full array");
    applyStimulus("conc_full", 3, 3, 32'h1234_5678, DEPTH, -1);

    $display("[TB] zero words and clamped word count");
    applyStimulus("n_zero", 2, 1, 32'h0, 0, -1);
    applyStimulus("n_200", 2, 3, 32'hA5A5_0F0F, 200, -1);

    $display("[TB] abort during read at address 3");
    fault[2] = 32'h8000_0000;
    fault[6] = 32'h1;
    applyStimulus("abort_rd3", 1, 2, 32'h0, 8, 3);
    clearFaults();

    $display("[TB] concurrent mode with a single word");
    fault[0] = 32'h10;
    applyStimulus("conc_n1", 3, 0, 32'h0, 1, -1);
    clearFaults();

    $display("[TB] randomized transactions");
    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(0, 3);
      p = $urandom_range(0, 3);
      s = $urandom;
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 24);
      clearFaults();
      k = $urandom_range(0, 3);
      for (int f = 0; f < k; f++) fault[$urandom_range(0, DEPTH-1)] = $urandom | 32'h1;
      applyStimulus($sformatf("rand%0d", r), m, p, s, n, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
